onehot_strobe_decoder: RTL and testbench
========================================

# onehot_strobe_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable, a valid/ready select input, and three operating modes: level (held one-hot), pulse (timed strobe), and scan (free-running one-hot rotation). It drives one-hot select lines for the CPU datapath: register-file write strobes, peripheral chip-selects, and multiplexed display digit scan. It replaces the fixed 3-to-8 combinational decoder wherever registered, timed, or sequenced selects are needed.

## Interface
- SEL_W, 3, select width; OUT_N = 2**SEL_W is a derived localparam and is not overridable
- HOLD_W, 4, width of the hold/step-period counter
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  1  block enable; low forces idle
- mode  in  2  00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved (behaves as en=0)
- hold_cycles  in  HOLD_W  pulse length minus 1 (PULSE) or step period minus 1 (SCAN)
- sel_valid  in  1  select request valid
- sel  in  SEL_W  select index
- sel_ready  out  1  select accepted when sel_valid && sel_ready
- out  out  OUT_N  registered one-hot, or all zeros
- out_valid  out  1  registered; high whenever out is non-zero
- busy  out  1  registered; high in PULSE_ON or SCAN state
- scan_wrap  out  1  registered one-cycle pulse, coincident with out returning from bit OUT_N-1 to bit 0

## Operation
- FSM states: IDLE, LEVEL, PULSE_ON, SCAN. The 2-bit mode code maps to its state in a shared package enum.
- Abort: en=0 or mode=11 in any state -> next state IDLE; next cycle out=0, out_valid=0, busy=0, scan_wrap=0. This covers a pulse in progress.
- sel_ready is combinational: en && ((mode==LEVEL && state∈{IDLE,LEVEL}) || (mode==PULSE && state==IDLE)).
- IDLE:
  - accepted sel in LEVEL mode -> LEVEL, out <= onehot(sel).
  - accepted sel in PULSE mode -> PULSE_ON, out <= onehot(sel), hold counter <= hold_cycles.
  - mode=SCAN && en -> SCAN, out <= bit 0, counter <= hold_cycles.
- LEVEL:
  - out holds until the next accepted sel, which replaces it; back-to-back accepts are allowed every cycle.
  - mode change away from LEVEL -> IDLE, out=0.
- PULSE_ON:
  - counter decrements each cycle. On the cycle the counter is 0, out <= 0 and state -> IDLE.
  - Result: out is high exactly hold_cycles+1 cycles.
  - A mode change to LEVEL or SCAN does not cut the pulse short; the new mode takes effect from IDLE.
- SCAN:
  - counter decrements each cycle. At 0: out rotates left by one, counter reloads hold_cycles (sampled at that edge).
  - Rotation from bit OUT_N-1 to bit 0 asserts scan_wrap for that one cycle.
  - sel is ignored and sel_ready=0.
  - mode change -> IDLE, out=0.
- Invariant: out is always zero or exactly one-hot; $onehot0(out) holds every cycle.

## Timing
- Reset values: out=0, out_valid=0, busy=0, scan_wrap=0, state=IDLE, counter=0. sel_ready follows its equation with state=IDLE.
- Latency: accept at edge N -> out valid after edge N (visible in cycle N+1). There is no combinational path from sel to out.
- hold_cycles=0:
  - PULSE gives a single-cycle strobe; the next accept is possible in the cycle the strobe is high? No: sel_ready is low in PULSE_ON, so the next accept comes one cycle after the strobe.
  - SCAN steps every cycle.
- Minimum pulse-to-pulse spacing is hold_cycles+2 cycles.
- rst_n asserted mid-pulse or mid-scan: outputs clear asynchronously. Deassertion is synchronised externally; the block needs no further recovery.
- Abort has priority over every other transition in the same cycle.

## Structure
- Package decoder_pkg:
  - mode_e (LEVEL, PULSE, SCAN, RSVD)
  - state_e (IDLE, LEVEL, PULSE_ON, SCAN)
- Sub-module onehot_dec #(SEL_W): purely combinational index-to-one-hot. It is the reusable successor of the fixed decoder and is instantiated once for the sel path.
- Top holds the FSM, hold counter, out register, and rotation logic.

## Test plan
- LEVEL, SEL_W=3: accept sel=5, then sel=2 on the next cycle -> out=8'b0010_0000 for one cycle, then 8'b0000_0100 held; out_valid=1 throughout.
- PULSE, hold_cycles=3: accept sel=7 -> out=8'b1000_0000 for exactly 4 cycles, then 0. sel_ready=0 for those 4 cycles, then 1 on the following cycle.
- PULSE, hold_cycles=0: back-to-back requests sel=1 and sel=6 -> 1-cycle strobes separated by one idle cycle.
- SCAN, hold_cycles=1: out steps bit0→bit7, each held 2 cycles. scan_wrap pulses once per 16 cycles, aligned with the return to bit 0; sel_valid is ignored.
- Abort: drop en in the 2nd cycle of a hold_cycles=5 pulse -> out=0 next cycle, state IDLE. rst_n=0 mid-scan -> all outputs 0 immediately.
- Random mode/en/sel stress: $onehot0(out) every cycle; out_valid == |out; busy matches state.

Source files
------------

// File: rtl/onehot_strobe_decoder_pkg.sv
// ============================================================================
// Module   : decoder_pkg
// Brief    : Shared mode and state encodings for onehot_strobe_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_pkg;

    // External mode code on the mode input
    typedef enum logic [1:0] {
        M_LEVEL = 2'b00,
        M_PULSE = 2'b01,
        M_SCAN  = 2'b10,
        M_RSVD  = 2'b11
    } mode_e;

    // Each state shares its mode code; the reserved code maps to IDLE
    typedef enum logic [1:0] {
        ST_LEVEL    = 2'b00,
        ST_PULSE_ON = 2'b01,
        ST_SCAN     = 2'b10,
        ST_IDLE     = 2'b11
    } state_e;

endpackage

`default_nettype wire

// File: rtl/onehot_strobe_decoder_dec.sv
// ============================================================================
// Module   : onehot_dec
// Brief    : Combinational SEL_W-to-2^SEL_W index-to-one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      idx,
    output logic [(1<<SEL_W)-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/onehot_strobe_decoder.sv
// ============================================================================
// Module   : onehot_strobe_decoder
// Brief    : Registered one-hot select driver with level, pulse and scan modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_strobe_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int HOLD_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [HOLD_W-1:0]     hold_cycles,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic                  sel_ready,
    output logic [(1<<SEL_W)-1:0] out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  scan_wrap
);

    localparam int OUT_N = 2**SEL_W;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [OUT_N-1:0]    r_out;
    logic [OUT_N-1:0]    w_out_nxt;
    logic [HOLD_W-1:0]   r_cnt;
    logic [HOLD_W-1:0]   w_cnt_nxt;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_scan_wrap;
    logic                w_wrap_nxt;
    logic [OUT_N-1:0]    w_sel_onehot;
    mode_e               w_mode;
    logic                w_abort;
    logic                w_sel_ready;
    logic                w_accept;

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_sel_dec (
        .idx    (sel),
        .onehot (w_sel_onehot)
    );

    always_comb begin
        w_mode      = mode_e'(mode);
        w_abort     = !en || (w_mode == M_RSVD);
        w_sel_ready = en && (((w_mode == M_LEVEL) &&
                              ((r_state == ST_IDLE) || (r_state == ST_LEVEL))) ||
                             ((w_mode == M_PULSE) && (r_state == ST_IDLE)));
        w_accept    = sel_valid && w_sel_ready;
    end

    // Abort is tested first so it overrides every state-specific transition
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_cnt_nxt   = r_cnt;
        w_wrap_nxt  = 1'b0;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_mode == M_LEVEL)) begin
                        w_state_nxt = ST_LEVEL;
                        w_out_nxt   = w_sel_onehot;
                    end else if (w_accept && (w_mode == M_PULSE)) begin
                        w_state_nxt = ST_PULSE_ON;
                        w_out_nxt   = w_sel_onehot;
                        w_cnt_nxt   = hold_cycles;
                    end else if (w_mode == M_SCAN) begin
                        w_state_nxt = ST_SCAN;
                        w_out_nxt   = {{(OUT_N-1){1'b0}}, 1'b1};
                        w_cnt_nxt   = hold_cycles;
                    end
                end
                ST_LEVEL: begin
                    if (w_mode != M_LEVEL) begin
                        w_state_nxt = ST_IDLE;
                        w_out_nxt   = '0;
                    end else if (w_accept) begin
                        w_out_nxt   = w_sel_onehot;
                    end
                end
                // A pulse runs to completion regardless of the mode input
                ST_PULSE_ON: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_out_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - HOLD_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (w_mode != M_SCAN) begin
                        w_state_nxt = ST_IDLE;
                        w_out_nxt   = '0;
                    end else if (r_cnt == '0) begin
                        w_out_nxt   = {r_out[OUT_N-2:0], r_out[OUT_N-1]};
                        w_cnt_nxt   = hold_cycles;
                        w_wrap_nxt  = r_out[OUT_N-1];
                    end else begin
                        w_cnt_nxt   = r_cnt - HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_scan_wrap <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= |w_out_nxt;
            r_busy      <= (w_state_nxt == ST_PULSE_ON) || (w_state_nxt == ST_SCAN);
            r_scan_wrap <= w_wrap_nxt;
        end
    end

    assign sel_ready = w_sel_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign scan_wrap = r_scan_wrap;

endmodule

`default_nettype wire

// File: tb/tb_onehot_strobe_decoder.sv
// ============================================================================
// Module   : tb_onehot_strobe_decoder
// Brief    : Scoreboard bench for onehot_strobe_decoder (SEL_W=3, HOLD_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_strobe_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] hold_cycles;
    logic       sel_valid;
    logic [2:0] sel;
    logic       sel_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       busy;
    logic       scan_wrap;

    onehot_strobe_decoder #(
        .SEL_W  (3),
        .HOLD_W (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .hold_cycles (hold_cycles),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .sel_ready   (sel_ready),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .scan_wrap   (scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] o;
        logic       v;
        logic       b;
        logic       w;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: 0 idle, 1 level, 2 pulse, 3 scan; scan tracked by bit index
    int         m_st;
    logic [7:0] m_out;
    int         m_cnt;
    int         m_idx;
    bit         m_wrap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit m_ready(input bit e, input logic [1:0] m);
        return e && ((m == 2'd0 && (m_st == 0 || m_st == 1)) || (m == 2'd1 && m_st == 0));
    endfunction

    task automatic m_reset();
        m_st = 0; m_out = '0; m_cnt = 0; m_idx = 0; m_wrap = 1'b0;
    endtask

    task automatic m_step(input bit e, input logic [1:0] m, input logic [3:0] h,
                          input bit v, input logic [2:0] s);
        bit acc;
        acc    = v && m_ready(e, m);
        m_wrap = 1'b0;
        if (!e || m == 2'd3) begin
            m_st = 0; m_out = '0;
        end else if (m_st == 0) begin
            if (acc && m == 2'd0) begin
                m_st = 1; m_out = 8'b1 << s;
            end else if (acc && m == 2'd1) begin
                m_st = 2; m_out = 8'b1 << s; m_cnt = int'(h);
            end else if (m == 2'd2) begin
                m_st = 3; m_idx = 0; m_out = 8'b1; m_cnt = int'(h);
            end
        end else if (m_st == 1) begin
            if (m != 2'd0) begin m_st = 0; m_out = '0; end
            else if (acc) m_out = 8'b1 << s;
        end else if (m_st == 2) begin
            if (m_cnt == 0) begin m_st = 0; m_out = '0; end
            else m_cnt--;
        end else begin
            if (m != 2'd2) begin m_st = 0; m_out = '0; end
            else if (m_cnt == 0) begin
                m_wrap = (m_idx == 7);
                m_idx  = (m_idx + 1) % 8;
                m_out  = 8'b1 << m_idx;
                m_cnt  = int'(h);
            end else m_cnt--;
        end
    endtask

    // One clock: drive at negedge, push expectation, compare after posedge
    task automatic step(input bit e, input logic [1:0] m, input logic [3:0] h,
                        input bit v, input logic [2:0] s);
        exp_t x;
        en = e; mode = m; hold_cycles = h; sel_valid = v; sel = s;
        #1;
        check_eq("sel_ready", 32'(sel_ready), 32'(m_ready(e, m)));
        m_step(e, m, h, v, s);
        x.o = m_out; x.v = (m_out != 8'h00); x.b = (m_st == 2 || m_st == 3); x.w = m_wrap;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        check_eq("out", 32'(out), 32'(x.o));
        check_eq("out_valid", 32'(out_valid), 32'(x.v));
        check_eq("busy", 32'(busy), 32'(x.b));
        check_eq("scan_wrap", 32'(scan_wrap), 32'(x.w));
        check_eq("onehot0", 32'($onehot0(out)), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; hold_cycles = '0; sel_valid = 1'b0; sel = '0;
        m_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_scan_wrap", 32'(scan_wrap), 32'd0);
        check_eq("rst_sel_ready", 32'(sel_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LEVEL: back-to-back accepts replace the held select
        step(1, 2'd0, 4'd0, 1, 3'd5);
        check_eq("lvl_sel5", 32'(out), 32'h20);
        step(1, 2'd0, 4'd0, 1, 3'd2);
        check_eq("lvl_sel2", 32'(out), 32'h04);
        step(1, 2'd0, 4'd0, 0, 3'd7);
        check_eq("lvl_hold", 32'(out), 32'h04);
        step(1, 2'd1, 4'd3, 0, 3'd0);
        check_eq("lvl_leave", 32'(out), 32'h00);

        // PULSE hold 3: four cycles high, ready returns afterwards
        cnt = 0;
        step(1, 2'd1, 4'd3, 1, 3'd7);
        if (out == 8'h80) cnt++;
        for (int i = 0; i < 5; i++) begin
            step(1, 2'd1, 4'd3, 0, 3'd0);
            if (out == 8'h80) cnt++;
        end
        check_eq("pulse_len", 32'(cnt), 32'd4);

        // PULSE hold 0: the second request waits out the strobe cycle
        step(1, 2'd1, 4'd0, 1, 3'd1);
        check_eq("strobe1", 32'(out), 32'h02);
        step(1, 2'd1, 4'd0, 1, 3'd6);
        check_eq("strobe_gap", 32'(out), 32'h00);
        step(1, 2'd1, 4'd0, 1, 3'd6);
        check_eq("strobe6", 32'(out), 32'h40);
        step(1, 2'd1, 4'd0, 0, 3'd0);

        // SCAN hold 1: wraps every 16 cycles, sel ignored
        step(0, 2'd2, 4'd1, 0, 3'd0);
        cnt = 0;
        for (int i = 0; i < 34; i++) begin
            step(1, 2'd2, 4'd1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            if (scan_wrap) begin
                cnt++;
                check_eq("wrap_bit0", 32'(out), 32'h01);
            end
        end
        check_eq("scan_wraps", 32'(cnt), 32'd2);
        step(0, 2'd2, 4'd1, 0, 3'd0);

        // Abort in the 2nd cycle of a hold 5 pulse
        step(1, 2'd1, 4'd5, 1, 3'd3);
        check_eq("abort_pre", 32'(out), 32'h08);
        step(0, 2'd1, 4'd5, 0, 3'd0);
        check_eq("abort_out", 32'(out), 32'h00);
        check_eq("abort_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-scan
        for (int i = 0; i < 5; i++) step(1, 2'd2, 4'd2, 0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_eq("arst_out", 32'(out), 32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_scan_wrap", 32'(scan_wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random stress against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
